// File: rtl/pool2_flatten_serializer.sv
// Buffers one 4x4x16 pooled map (position-major beats) and re-emits it channel-major as int8 with valid/ready.
// First element is valid the cycle after the 16th beat; holds data while !out_ready; beats arriving mid-drain are dropped and flagged.
module pool2_flatten_serializer #(
    parameter int NUM_CH    = 16,
    parameter int NUM_POS   = 16,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [31:0]          in_ch0,
    input  logic [31:0]          in_ch1,
    input  logic [31:0]          in_ch2,
    input  logic [31:0]          in_ch3,
    input  logic [31:0]          in_ch4,
    input  logic [31:0]          in_ch5,
    input  logic [31:0]          in_ch6,
    input  logic [31:0]          in_ch7,
    input  logic [31:0]          in_ch8,
    input  logic [31:0]          in_ch9,
    input  logic [31:0]          in_ch10,
    input  logic [31:0]          in_ch11,
    input  logic [31:0]          in_ch12,
    input  logic [31:0]          in_ch13,
    input  logic [31:0]          in_ch14,
    input  logic [31:0]          in_ch15,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [7:0]           out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overflow
);

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    localparam int POS_W = $clog2(NUM_POS);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int IDX_W = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH * NUM_POS - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);
    localparam logic signed [31:0] MAX_V = 2 ** (OUT_WIDTH - 1) - 1;
    localparam logic signed [31:0] MIN_V = -(2 ** (OUT_WIDTH - 1));

    logic [31:0]          w_in   [NUM_CH];
    logic [OUT_WIDTH-1:0] w_conv [NUM_CH];

    logic [OUT_WIDTH-1:0] r_buf [NUM_CH][NUM_POS];
    logic [0:0]           r_state;
    logic [POS_W-1:0]     r_wr_pos;
    logic [IDX_W-1:0]     r_rd_idx;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 r_overflow;

    logic                 w_hs;
    logic                 w_final;
    logic                 w_accept;
    logic                 w_wr_last;
    logic [IDX_W-1:0]     w_nxt_idx;
    logic [OUT_WIDTH-1:0] w_nxt_elem;
    logic [OUT_WIDTH-1:0] w_first;

    assign w_in[0]  = in_ch0;
    assign w_in[1]  = in_ch1;
    assign w_in[2]  = in_ch2;
    assign w_in[3]  = in_ch3;
    assign w_in[4]  = in_ch4;
    assign w_in[5]  = in_ch5;
    assign w_in[6]  = in_ch6;
    assign w_in[7]  = in_ch7;
    assign w_in[8]  = in_ch8;
    assign w_in[9]  = in_ch9;
    assign w_in[10] = in_ch10;
    assign w_in[11] = in_ch11;
    assign w_in[12] = in_ch12;
    assign w_in[13] = in_ch13;
    assign w_in[14] = in_ch14;
    assign w_in[15] = in_ch15;

    // Saturate the 32-bit pooled value into the signed output range.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_conv[c] = w_in[c][OUT_WIDTH-1:0];
            if ($signed(w_in[c]) > MAX_V) begin
                w_conv[c] = MAX_V[OUT_WIDTH-1:0];
            end else if ($signed(w_in[c]) < MIN_V) begin
                w_conv[c] = MIN_V[OUT_WIDTH-1:0];
            end
        end
    end

    assign w_hs       = r_out_valid & out_ready;
    assign w_final    = w_hs & (r_rd_idx == LAST_IDX);
    assign w_accept   = in_valid & ((r_state == S_FILL) | w_final);
    assign w_wr_last  = (r_wr_pos == LAST_POS);
    assign w_nxt_idx  = r_rd_idx + IDX_W'(1);
    assign w_nxt_elem = r_buf[w_nxt_idx[IDX_W-1 -: CH_W]][w_nxt_idx[POS_W-1:0]];
    assign w_first    = (r_wr_pos == '0) ? w_conv[0] : r_buf[0][0];

    // Feature-map storage carries no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_buf[c][r_wr_pos] <= w_conv[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_wr_pos    <= '0;
            r_rd_idx    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (r_state == S_FILL) begin
            if (in_valid) begin
                if (w_wr_last) begin
                    r_wr_pos    <= '0;
                    r_state     <= S_DRAIN;
                    r_rd_idx    <= '0;
                    r_out_data  <= w_first;
                    r_out_valid <= 1'b1;
                end else begin
                    r_wr_pos <= r_wr_pos + 1'b1;
                end
            end
        end else begin
            if (w_final) begin
                r_out_valid <= 1'b0;
                r_state     <= S_FILL;
                // A beat landing on the final handshake starts the next frame.
                if (in_valid) begin
                    r_wr_pos <= POS_W'(1);
                end
            end else if (w_hs) begin
                r_rd_idx   <= w_nxt_idx;
                r_out_data <= w_nxt_elem;
            end
            if (in_valid & ~w_final) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_idx   = r_rd_idx;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_valid & (r_rd_idx == LAST_IDX);
    assign busy      = (r_state == S_DRAIN);
    assign overflow  = r_overflow;

endmodule
